// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared constants for the pipelined ID stage: opcode and
//               funct encodings of the supported logic/shift subset, ALU
//               operation and ALU unit-select codes, and field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    // SPECIAL funct codes (inst[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_NOP = 8'h00,
        ALU_SRL = 8'h02,
        ALU_SRA = 8'h03,
        ALU_AND = 8'h24,
        ALU_OR  = 8'h25,
        ALU_XOR = 8'h26,
        ALU_NOR = 8'h27,
        ALU_SLL = 8'h7C
    } aluop_e;

    typedef enum logic [ALUSEL_W-1:0] {
        SEL_NOP   = 3'd0,
        SEL_LOGIC = 3'd1,
        SEL_SHIFT = 3'd2
    } alusel_e;

    // Destination used by bubbles and undecodable instructions
    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

endpackage : id_pkg
`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pipe_if
// Description : ID/EX pipeline bus. The ID stage drives it (master) and the
//               EX stage consumes it (slave).
//   ex_valid_o        : slot holds a real instruction
//   ex_pc_o           : instruction address
//   ex_aluop_o        : ALU operation code
//   ex_alusel_o       : ALU unit select
//   ex_reg1_o/reg2_o  : resolved operands
//   ex_wd_o           : destination register
//   ex_wreg_o         : destination write enable
//   ex_inst_invalid_o : instruction could not be decoded
// Revision    : 1.0 - initial release
// ============================================================================
interface id_stage_pipe_if
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic                ex_valid_o;
    logic [31:0]         ex_pc_o;
    logic [ALUOP_W-1:0]  ex_aluop_o;
    logic [ALUSEL_W-1:0] ex_alusel_o;
    logic [DATA_W-1:0]   ex_reg1_o;
    logic [DATA_W-1:0]   ex_reg2_o;
    logic [REG_AW-1:0]   ex_wd_o;
    logic                ex_wreg_o;
    logic                ex_inst_invalid_o;

    modport master (
        output ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o,
               ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_inst_invalid_o
    );

    modport slave (
        input  ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o,
               ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_inst_invalid_o
    );
endinterface : id_stage_pipe_if
`default_nettype wire

// File: rtl/id_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : id_fwd_mux
// Description : Operand selector for one register read port. Chooses between
//               the immediate, register zero, forwarded write data (lowest
//               source index wins) and register-file data, and flags when
//               the winning forward source is a load whose data is not ready.
//   raddr_i       : register address being read
//   re_i          : port reads the register file (else operand = imm_i)
//   rf_rdata_i    : register-file read data
//   imm_i         : immediate / shift amount used when re_i is low
//   fwd_*_i       : packed forwarding buses, source k at slice k
//   operand_o     : selected operand
//   load_hit_o    : selected forward source is an unfinished load
// Revision    : 1.0 - initial release
// ============================================================================
module id_fwd_mux #(
    parameter int NUM_FWD = 2,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5
) (
    input  wire logic [REG_AW-1:0]         raddr_i,
    input  wire logic                      re_i,
    input  wire logic [DATA_W-1:0]         rf_rdata_i,
    input  wire logic [DATA_W-1:0]         imm_i,
    input  wire logic [NUM_FWD-1:0]        fwd_we_i,
    input  wire logic [NUM_FWD-1:0]        fwd_is_load_i,
    input  wire logic [NUM_FWD*REG_AW-1:0] fwd_waddr_i,
    input  wire logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    output logic      [DATA_W-1:0]         operand_o,
    output logic                           load_hit_o
);

    always_comb begin
        operand_o  = imm_i;
        load_hit_o = 1'b0;
        if (re_i) begin
            if (raddr_i == '0) begin
                operand_o = '0;
            end else begin
                operand_o = rf_rdata_i;
                // Scan oldest to youngest so the youngest match is applied last
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (fwd_we_i[k] && (fwd_waddr_i[k*REG_AW +: REG_AW] == raddr_i)) begin
                        operand_o  = fwd_wdata_i[k*DATA_W +: DATA_W];
                        load_hit_o = fwd_is_load_i[k];
                    end
                end
            end
        end
    end

endmodule : id_fwd_mux
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pipe
// Description : Pipelined instruction-decode stage. Decodes the logic/shift
//               subset, resolves operands with multi-source forwarding,
//               detects load-use hazards (stalling IF/ID and inserting a
//               bubble) and owns the ID/EX register plus a saturating count
//               of hazard stall cycles.
//   clk, rst              : clock; asynchronous active-low reset
//   if_valid_i/pc_i/inst_i: instruction from the IF/ID register
//   reg*_re_o/raddr_o     : register-file read request (combinational)
//   reg*_rdata_i          : register-file read data
//   fwd_*_i               : write ports of later stages, index 0 youngest
//   ex_stall_i, flush_i   : EX back-pressure, kill instruction in ID
//   stall_o               : hold PC and IF/ID
//   ex_if                 : ID/EX register outputs
//   stall_cnt_o           : saturating load-use stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      if_valid_i,
    input  wire logic [31:0]               pc_i,
    input  wire logic [31:0]               inst_i,
    output logic                           reg1_re_o,
    output logic                           reg2_re_o,
    output logic      [REG_AW-1:0]         reg1_raddr_o,
    output logic      [REG_AW-1:0]         reg2_raddr_o,
    input  wire logic [DATA_W-1:0]         reg1_rdata_i,
    input  wire logic [DATA_W-1:0]         reg2_rdata_i,
    input  wire logic [NUM_FWD-1:0]        fwd_we_i,
    input  wire logic [NUM_FWD-1:0]        fwd_is_load_i,
    input  wire logic [NUM_FWD*REG_AW-1:0] fwd_waddr_i,
    input  wire logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  wire logic                      ex_stall_i,
    input  wire logic                      flush_i,
    output logic                           stall_o,
    id_stage_pipe_if.master                ex_if,
    output logic      [CNT_W-1:0]          stall_cnt_o
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign op    = inst_i[31:26];
    assign funct = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    aluop_e            dec_aluop;
    alusel_e           dec_alusel;
    logic              dec_re1;
    logic              dec_re2;
    logic [DATA_W-1:0] dec_imm1;
    logic [DATA_W-1:0] dec_imm2;
    logic [REG_AW-1:0] dec_wd;
    logic              dec_wreg;
    logic              dec_invalid;
    logic              logic_imm;

    always_comb begin
        dec_aluop   = ALU_NOP;
        dec_alusel  = SEL_NOP;
        dec_re1     = 1'b0;
        dec_re2     = 1'b0;
        dec_imm1    = '0;
        dec_imm2    = '0;
        dec_wd      = REG_AW'(NOP_REG_ADDR);
        dec_wreg    = 1'b0;
        dec_invalid = 1'b1;
        logic_imm   = 1'b0;

        case (op)
            OP_ORI:  begin dec_aluop = ALU_OR;  logic_imm = 1'b1; end
            OP_ANDI: begin dec_aluop = ALU_AND; logic_imm = 1'b1; end
            OP_XORI: begin dec_aluop = ALU_XOR; logic_imm = 1'b1; end
            OP_LUI: begin
                // Executed as 0 | (imm << 16), so no register is read
                dec_aluop   = ALU_OR;
                dec_alusel  = SEL_LOGIC;
                dec_imm2    = DATA_W'({imm16, 16'h0000});
                dec_wd      = REG_AW'(inst_i[20:16]);
                dec_wreg    = 1'b1;
                dec_invalid = 1'b0;
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        case (funct)
                            FN_AND:  dec_aluop = ALU_AND;
                            FN_OR:   dec_aluop = ALU_OR;
                            FN_XOR:  dec_aluop = ALU_XOR;
                            default: dec_aluop = ALU_NOR;
                        endcase
                        dec_alusel  = SEL_LOGIC;
                        dec_re1     = 1'b1;
                        dec_re2     = 1'b1;
                        dec_wd      = REG_AW'(inst_i[15:11]);
                        dec_wreg    = 1'b1;
                        dec_invalid = 1'b0;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        case (funct)
                            FN_SLL:  dec_aluop = ALU_SLL;
                            FN_SRL:  dec_aluop = ALU_SRL;
                            default: dec_aluop = ALU_SRA;
                        endcase
                        // Shift amount travels on operand 1, value on operand 2
                        dec_alusel  = SEL_SHIFT;
                        dec_re2     = 1'b1;
                        dec_imm1    = DATA_W'(inst_i[10:6]);
                        dec_wd      = REG_AW'(inst_i[15:11]);
                        dec_wreg    = 1'b1;
                        dec_invalid = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        if (logic_imm) begin
            dec_alusel  = SEL_LOGIC;
            dec_re1     = 1'b1;
            dec_imm2    = DATA_W'(imm16);
            dec_wd      = REG_AW'(inst_i[20:16]);
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
        end
    end

    assign reg1_re_o    = dec_re1;
    assign reg2_re_o    = dec_re2;
    assign reg1_raddr_o = REG_AW'(inst_i[25:21]);
    assign reg2_raddr_o = REG_AW'(inst_i[20:16]);

    // ------------------------------------------------------------------
    // Operand selection, one mux per read port
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;
    logic              load_hit1;
    logic              load_hit2;

    id_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
        .raddr_i       (reg1_raddr_o),
        .re_i          (dec_re1),
        .rf_rdata_i    (reg1_rdata_i),
        .imm_i         (dec_imm1),
        .fwd_we_i      (fwd_we_i),
        .fwd_is_load_i (fwd_is_load_i),
        .fwd_waddr_i   (fwd_waddr_i),
        .fwd_wdata_i   (fwd_wdata_i),
        .operand_o     (opnd1),
        .load_hit_o    (load_hit1)
    );

    id_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
        .raddr_i       (reg2_raddr_o),
        .re_i          (dec_re2),
        .rf_rdata_i    (reg2_rdata_i),
        .imm_i         (dec_imm2),
        .fwd_we_i      (fwd_we_i),
        .fwd_is_load_i (fwd_is_load_i),
        .fwd_waddr_i   (fwd_waddr_i),
        .fwd_wdata_i   (fwd_wdata_i),
        .operand_o     (opnd2),
        .load_hit_o    (load_hit2)
    );

    logic hazard;
    assign hazard  = if_valid_i & (load_hit1 | load_hit2);
    // Gated by rst so the fetch side is never held while the core is in reset
    assign stall_o = rst & ~flush_i & (hazard | ex_stall_i);

    // ------------------------------------------------------------------
    // ID/EX register and stall counter
    // ------------------------------------------------------------------
    logic                ex_valid_d,   ex_valid_q;
    logic [31:0]         ex_pc_d,      ex_pc_q;
    logic [ALUOP_W-1:0]  ex_aluop_d,   ex_aluop_q;
    logic [ALUSEL_W-1:0] ex_alusel_d,  ex_alusel_q;
    logic [DATA_W-1:0]   ex_reg1_d,    ex_reg1_q;
    logic [DATA_W-1:0]   ex_reg2_d,    ex_reg2_q;
    logic [REG_AW-1:0]   ex_wd_d,      ex_wd_q;
    logic                ex_wreg_d,    ex_wreg_q;
    logic                ex_invalid_d, ex_invalid_q;
    logic [CNT_W-1:0]    stall_cnt_d,  stall_cnt_q;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_aluop_d   = ex_aluop_q;
        ex_alusel_d  = ex_alusel_q;
        ex_reg1_d    = ex_reg1_q;
        ex_reg2_d    = ex_reg2_q;
        ex_wd_d      = ex_wd_q;
        ex_wreg_d    = ex_wreg_q;
        ex_invalid_d = ex_invalid_q;

        if (!flush_i && ex_stall_i) begin
            // EX is not accepting: hold the slot as-is
        end else if (flush_i || hazard || !if_valid_i) begin
            ex_valid_d   = 1'b0;
            ex_pc_d      = '0;
            ex_aluop_d   = '0;
            ex_alusel_d  = '0;
            ex_reg1_d    = '0;
            ex_reg2_d    = '0;
            ex_wd_d      = '0;
            ex_wreg_d    = 1'b0;
            ex_invalid_d = 1'b0;
        end else begin
            ex_valid_d   = 1'b1;
            ex_pc_d      = pc_i;
            ex_aluop_d   = dec_aluop;
            ex_alusel_d  = dec_alusel;
            ex_reg1_d    = opnd1;
            ex_reg2_d    = opnd2;
            ex_wd_d      = dec_wd;
            ex_wreg_d    = dec_wreg;
            ex_invalid_d = dec_invalid;
        end

        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush_i && !ex_stall_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_aluop_q   <= '0;
            ex_alusel_q  <= '0;
            ex_reg1_q    <= '0;
            ex_reg2_q    <= '0;
            ex_wd_q      <= '0;
            ex_wreg_q    <= 1'b0;
            ex_invalid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_aluop_q   <= ex_aluop_d;
            ex_alusel_q  <= ex_alusel_d;
            ex_reg1_q    <= ex_reg1_d;
            ex_reg2_q    <= ex_reg2_d;
            ex_wd_q      <= ex_wd_d;
            ex_wreg_q    <= ex_wreg_d;
            ex_invalid_q <= ex_invalid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_if.ex_valid_o        = ex_valid_q;
    assign ex_if.ex_pc_o           = ex_pc_q;
    assign ex_if.ex_aluop_o        = ex_aluop_q;
    assign ex_if.ex_alusel_o       = ex_alusel_q;
    assign ex_if.ex_reg1_o         = ex_reg1_q;
    assign ex_if.ex_reg2_o         = ex_reg2_q;
    assign ex_if.ex_wd_o           = ex_wd_q;
    assign ex_if.ex_wreg_o         = ex_wreg_q;
    assign ex_if.ex_inst_invalid_o = ex_invalid_q;
    assign stall_cnt_o             = stall_cnt_q;

endmodule : id_stage_pipe
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_pipe
// Description : Scoreboard bench for id_stage_pipe. Stimulus computes the
//               expected ID/EX contents from the instruction-set rules and
//               queues them; a monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_pipe;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           if_valid_i;
    logic [31:0]    pc_i, inst_i;
    logic           reg1_re_o, reg2_re_o;
    logic [AW-1:0]  reg1_raddr_o, reg2_raddr_o;
    logic [DW-1:0]  reg1_rdata_i, reg2_rdata_i;
    logic [NF-1:0]  fwd_we_i, fwd_is_load_i;
    logic [NF*AW-1:0] fwd_waddr_i;
    logic [NF*DW-1:0] fwd_wdata_i;
    logic           ex_stall_i, flush_i, stall_o;
    logic [CW-1:0]  stall_cnt_o;

    id_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW)) ex_if ();

    id_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o),
        .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
        .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
        .fwd_we_i(fwd_we_i), .fwd_is_load_i(fwd_is_load_i),
        .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
        .ex_stall_i(ex_stall_i), .flush_i(flush_i), .stall_o(stall_o),
        .ex_if(ex_if), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        inv;
    } idex_t;

    typedef struct packed {
        idex_t         ex;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t  sb_q[$];
    idex_t m_ex;
    int    m_cnt;
    int    n_chk  = 0;
    int    n_fail = 0;

    // Forwarding sources as seen by the model
    logic        f_we[NF];
    logic        f_ld[NF];
    logic [4:0]  f_ad[NF];
    logic [31:0] f_dt[NF];

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic idex_t dut_ex();
        idex_t a;
        a = '{ex_if.ex_valid_o, ex_if.ex_pc_o, ex_if.ex_aluop_o, ex_if.ex_alusel_o,
              ex_if.ex_reg1_o, ex_if.ex_reg2_o, ex_if.ex_wd_o, ex_if.ex_wreg_o,
              ex_if.ex_inst_invalid_o};
        return a;
    endfunction

    // Instruction-set reference: what each supported encoding means
    function automatic void ref_dec(input logic [31:0] w, output logic ok,
                                    output logic [7:0] aop, output logic [2:0] asel,
                                    output logic u1, output logic u2,
                                    output logic [31:0] i1, output logic [31:0] i2,
                                    output logic [4:0] wd);
        logic [5:0] op, fn;
        op = w[31:26]; fn = w[5:0];
        ok = 1'b1; u1 = 1'b0; u2 = 1'b0; i1 = '0; i2 = '0; wd = '0; aop = '0; asel = '0;
        if (op == 6'h0d || op == 6'h0c || op == 6'h0e) begin
            u1 = 1'b1; i2 = {16'h0, w[15:0]}; wd = w[20:16]; asel = 3'd1;
            aop = (op == 6'h0d) ? 8'h25 : (op == 6'h0c) ? 8'h24 : 8'h26;
        end else if (op == 6'h0f) begin
            i2 = {w[15:0], 16'h0}; wd = w[20:16]; asel = 3'd1; aop = 8'h25;
        end else if (op == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
            u1 = 1'b1; u2 = 1'b1; wd = w[15:11]; asel = 3'd1; aop = {2'b00, fn};
        end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
            u2 = 1'b1; i1 = {27'h0, w[10:6]}; wd = w[15:11]; asel = 3'd2;
            aop = (fn == 6'h00) ? 8'h7c : {2'b00, fn};
        end else begin
            ok = 1'b0;
        end
    endfunction

    function automatic void ref_opnd(input logic use_rf, input logic [4:0] ra,
                                     input logic [31:0] rf, input logic [31:0] imm,
                                     output logic [31:0] v, output logic ld);
        v = imm; ld = 1'b0;
        if (use_rf) begin
            if (ra == 5'd0) v = '0;
            else begin
                v = rf;
                for (int k = 0; k < NF; k++) begin
                    if (f_we[k] && f_ad[k] == ra) begin
                        v = f_dt[k]; ld = f_ld[k];
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic clr_fwd();
        for (int k = 0; k < NF; k++) begin
            f_we[k] = 1'b0; f_ld[k] = 1'b0; f_ad[k] = '0; f_dt[k] = '0;
        end
    endtask

    task automatic set_fwd(input int k, input logic we, input logic ld,
                           input logic [4:0] ad, input logic [31:0] dt);
        f_we[k] = we; f_ld[k] = ld; f_ad[k] = ad; f_dt[k] = dt;
    endtask

    // One cycle of stimulus plus the expected ID/EX state after the next edge
    task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic iv,
                        input logic [31:0] rf1, input logic [31:0] rf2,
                        input logic es, input logic fl);
        logic ok, u1, u2, ld1, ld2, hz;
        logic [7:0]  aop;
        logic [2:0]  asel;
        logic [31:0] i1, i2, o1, o2;
        logic [4:0]  wd;
        exp_t e;
        @(negedge clk);
        inst_i = inst; pc_i = pc; if_valid_i = iv;
        reg1_rdata_i = rf1; reg2_rdata_i = rf2;
        ex_stall_i = es; flush_i = fl;
        for (int k = 0; k < NF; k++) begin
            fwd_we_i[k]                 = f_we[k];
            fwd_is_load_i[k]            = f_ld[k];
            fwd_waddr_i[k*AW +: AW]     = f_ad[k];
            fwd_wdata_i[k*DW +: DW]     = f_dt[k];
        end
        #1;
        ref_dec(inst, ok, aop, asel, u1, u2, i1, i2, wd);
        ref_opnd(u1, inst[25:21], rf1, i1, o1, ld1);
        ref_opnd(u2, inst[20:16], rf2, i2, o2, ld2);
        hz = iv && (ld1 || ld2);
        chk("stall_o", 128'(stall_o), 128'(!fl && (hz || es)));
        chk("read_en", 128'({reg1_re_o, reg2_re_o}), 128'({u1, u2}));

        if (fl)             m_ex = '0;
        else if (es)        m_ex = m_ex;
        else if (hz || !iv) m_ex = '0;
        else                m_ex = '{1'b1, pc, aop, asel, o1, o2, wd, ok, !ok};
        if (hz && !fl && !es && m_cnt < (2**CW - 1)) m_cnt++;
        e.ex  = m_ex;
        e.cnt = CW'(m_cnt);
        sb_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge while stimulus is active
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("idex", 128'(dut_ex()), 128'(mon_e.ex));
                chk("stall_cnt", 128'(stall_cnt_o), 128'(mon_e.cnt));
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] ops[4];
        logic [5:0] fns[7];
        ops = '{6'h0d, 6'h0c, 6'h0e, 6'h0f};
        fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 31)); sh = 5'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2:    return {ops[$urandom_range(0, 3)], rs, rt, 16'($urandom)};
            3, 4, 5, 6, 7: return {6'h00, rs, rt, rd, sh, fns[$urandom_range(0, 6)]};
            8:          return $urandom;
            default:    return {6'h00, rs, rt, rd, sh, 6'h01};
        endcase
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < NF; k++)
                set_fwd(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                        5'($urandom_range(0, 3)), $urandom);
            step(rand_inst(), $urandom, ($urandom_range(0, 9) != 0), $urandom, $urandom,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end
    endtask

    initial begin
        rst = 1'b0;
        m_ex = '0; m_cnt = 0;
        clr_fwd();
        if_valid_i = 1'b0; pc_i = '0; inst_i = '0;
        reg1_rdata_i = '0; reg2_rdata_i = '0;
        fwd_we_i = '0; fwd_is_load_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0;
        ex_stall_i = 1'b0; flush_i = 1'b0;

        // Reset held with random activity, including a requested EX stall
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inst_i = 32'h34011234; pc_i = $urandom; if_valid_i = 1'b1;
            reg1_rdata_i = $urandom; reg2_rdata_i = $urandom;
            fwd_we_i = '1; fwd_is_load_i = '1; fwd_waddr_i = {5'd1, 5'd0};
            fwd_wdata_i = {$urandom, $urandom};
            ex_stall_i = 1'b1; flush_i = 1'b0;
            #1;
            chk("rst_idex", 128'(dut_ex()), 128'(0));
            chk("rst_cnt", 128'(stall_cnt_o), 128'(0));
            chk("rst_stall", 128'(stall_o), 128'(0));
        end
        @(negedge clk);
        ex_stall_i = 1'b0;
        rst = 1'b1;

        // ORI $1,$0,0x1234
        clr_fwd();
        step(32'h34011234, 32'h100, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        // OR $3,$1,$2 with two sources for $1: youngest wins
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'hAAAA0000);
        set_fwd(1, 1'b1, 1'b0, 5'd1, 32'h5555FFFF);
        step(32'h00221825, 32'h104, 1'b1, 32'h12345678, 32'h0000000F, 1'b0, 1'b0);
        // Load-use on $2, then the load data becomes available
        set_fwd(0, 1'b1, 1'b1, 5'd2, 32'h0);
        step(32'h00221825, 32'h108, 1'b1, 32'h12345678, 32'h0000000F, 1'b0, 1'b0);
        set_fwd(0, 1'b1, 1'b0, 5'd2, 32'h77);
        step(32'h00221825, 32'h108, 1'b1, 32'h12345678, 32'h0000000F, 1'b0, 1'b0);
        // A load in MEM shadowed by a non-load in EX is not a hazard
        set_fwd(1, 1'b1, 1'b1, 5'd2, 32'h99);
        step(32'h00221825, 32'h10C, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        // SLL $4,$0,3 with a forward targeting $0
        clr_fwd();
        set_fwd(0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
        step(32'h000020C0, 32'h110, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0);
        // EX stall for two cycles holds the slot
        clr_fwd();
        step(32'h3C05ABCD, 32'h114, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        step(32'h3C05ABCD, 32'h114, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        // Flush beats EX stall
        step(32'h3C05ABCD, 32'h114, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
        // Undecodable opcode
        step(32'hFC000000, 32'h118, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
        // Drive enough hazards to reach the counter ceiling
        set_fwd(0, 1'b1, 1'b1, 5'd1, 32'h0);
        for (int i = 0; i < 2**CW + 3; i++)
            step(32'h00221825, 32'h11C, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        rand_cycles(300);

        // Asynchronous reset with a live slot and non-zero counter
        clr_fwd();
        step(32'h34011234, 32'h200, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_idex", 128'(dut_ex()), 128'(0));
        chk("async_rst_cnt", 128'(stall_cnt_o), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        m_ex = '0; m_cnt = 0;

        rand_cycles(200);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_id_stage_pipe
`default_nettype wire
